// File: rtl/ram_slave.sv
// rtl/ram_slave.sv - word-addressed burst RAM slave with separate write/read request channels
// One burst at a time; a write request wins over a read request presented in the same cycle.
module ram_slave #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int LWIDTH = 8,
    parameter int MWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] awaddr,
    input  logic [LWIDTH-1:0] awlen,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DWIDTH-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    output logic              wlast,
    input  logic [AWIDTH-1:0] araddr,
    input  logic [LWIDTH-1:0] arlen,
    input  logic              arvalid,
    output logic              arready,
    output logic [DWIDTH-1:0] rdata,
    output logic              rvalid,
    input  logic              rready,
    output logic              rlast
);

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

    localparam logic [MWIDTH-1:0] IDX_ONE = 1;
    localparam logic [LWIDTH-1:0] LEN_ONE = 1;
    localparam logic [LWIDTH-1:0] LEN_ZERO = '0;

    state_t            state_q;
    logic [MWIDTH-1:0] idx_q, idx_d;
    logic [LWIDTH-1:0] len_q;
    logic [LWIDTH-1:0] cnt_q, cnt_d;
    logic [DWIDTH-1:0] rdata_q;
    logic              rvalid_q;
    logic              rlast_q;
    logic [DWIDTH-1:0] mem [2**MWIDTH];

    logic [MWIDTH-1:0] aw_idx, ar_idx;
    logic              aw_hs, ar_hs, w_beat;
    logic              unused_addr_bits;

    // Byte-offset and high address bits are deliberately dropped: the array aliases.
    assign aw_idx = awaddr[MWIDTH+1:2];
    assign ar_idx = araddr[MWIDTH+1:2];
    assign unused_addr_bits = ^{awaddr[1:0], awaddr[AWIDTH-1:MWIDTH+2],
                                araddr[1:0], araddr[AWIDTH-1:MWIDTH+2]};

    assign awready = rst && (state_q == IDLE);
    assign arready = rst && (state_q == IDLE) && !awvalid;
    assign wvalid  = (state_q == WRITE);
    assign wlast   = wvalid && (cnt_q == len_q);
    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;

    assign aw_hs  = awvalid && awready;
    assign ar_hs  = arvalid && arready;
    assign w_beat = wvalid && wready;
    assign idx_d  = idx_q + IDX_ONE;
    assign cnt_d  = cnt_q + LEN_ONE;

    // Storage is intentionally not reset; state_q drops to IDLE asynchronously so no beat lands during reset.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            mem[idx_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        idx_q   <= aw_idx;
                        len_q   <= awlen;
                        cnt_q   <= '0;
                        state_q <= WRITE;
                    end else if (ar_hs) begin
                        idx_q    <= ar_idx;
                        len_q    <= arlen;
                        cnt_q    <= '0;
                        rdata_q  <= mem[ar_idx];
                        rvalid_q <= 1'b1;
                        rlast_q  <= (arlen == LEN_ZERO);
                        state_q  <= READ;
                    end
                end
                WRITE: begin
                    if (wready) begin
                        idx_q <= idx_d;
                        cnt_q <= cnt_d;
                        if (wlast) begin
                            state_q <= IDLE;
                        end
                    end
                end
                READ: begin
                    // Output registers hold while the initiator stalls.
                    if (rready) begin
                        if (rlast_q) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            idx_q   <= idx_d;
                            cnt_q   <= cnt_d;
                            rdata_q <= mem[idx_d];
                            rlast_q <= (cnt_d == len_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
